reg_mem_bist: RTL and testbench
===============================

// Module: reg_mem_bist
// PURPOSE
//  Hardware initiator for the reg_mem register memory port (addr/data_in/wen ->
//  data_out). On start, writes a deterministic pattern to every word, reads all
//  words back, compares against the expected pattern and reports pass/fail with
//  an error count and the first failing address. Used for power-on self-test.
// PARAMETERS
//  DATA_WIDTH  8   memory word width in bits
//  ADDR_WIDTH  5   memory address width in bits
//  DEPTH       32  words tested, addresses 0..DEPTH-1; 1 <= DEPTH <= 2**ADDR_WIDTH
//  SEED        10  pattern base: word(a) = (a + SEED) mod 2**DATA_WIDTH
//  RD_LAT      1   memory read latency in cycles; legal values 0 or 1
// PORTS
//  clk             in   1             single clock, rising edge
//  rst             in   1             asynchronous, active-high reset
//  start           in   1             run request, sampled in IDLE/DONE only
//  invert          in   1             sampled with start: 1 = use ~word(a)
//  mem_addr        out  ADDR_WIDTH    to reg_mem addr
//  mem_wdata       out  DATA_WIDTH    to reg_mem data_in
//  mem_wen         out  1             to reg_mem wen
//  mem_rdata       in   DATA_WIDTH    from reg_mem data_out
//  busy            out  1             run in progress (WRITE/READ/DRAIN)
//  done            out  1             run finished; held until next start
//  pass            out  1             valid with done: 1 = err_count == 0
//  err_count       out  ADDR_WIDTH+1  mismatching words in last run
//  first_err_addr  out  ADDR_WIDTH    address of first mismatch, 0 if none
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; all outputs 0, mem_wen 0 at once.
//  - All outputs are registered. States IDLE, WRITE, READ, DRAIN, DONE.
//  - IDLE/DONE: start=1 at edge k -> WRITE; latch invert; clear err_count,
//    first_err_addr, done, pass; busy=1. start ignored in WRITE/READ/DRAIN.
//  - WRITE: cycles k..k+DEPTH-1 drive mem_wen=1, mem_addr=a (0..DEPTH-1, +1 per
//    cycle), mem_wdata=pattern(a). After a=DEPTH-1 -> READ.
//  - READ: cycles k+DEPTH..k+2*DEPTH-1 drive mem_wen=0, mem_addr=a ascending;
//    mem_wdata holds pattern(a) (don't-care to memory).
//  - Compare: mem_rdata for address a is sampled RD_LAT cycles after a is
//    presented (RD_LAT=0: same cycle). Expected value and address travel in a
//    RD_LAT-deep pipeline beside the request. Mismatch: err_count += 1; if it
//    is the first mismatch of the run, first_err_addr = a.
//  - DRAIN: RD_LAT cycles (skipped when RD_LAT=0) to finish last compare.
//  - DONE entered at edge k+2*DEPTH+RD_LAT: busy=0, done=1,
//    pass=(err_count==0), including the final compare's result. mem_wen=0,
//    mem_addr=0. Results held until next start or reset.
//  - Pattern arithmetic: (a + SEED) truncated to DATA_WIDTH; invert applies
//    bitwise NOT after truncation. err_count cannot overflow (DEPTH <=
//    2**ADDR_WIDTH < 2**(ADDR_WIDTH+1)).
//  - Reset mid-run: abort; memory contents are left as partially written.
//  - start held high in DONE: a new run begins on the first DONE edge.
// TESTING
//  1 Ideal reg_mem, DEPTH=8, SEED=10, RD_LAT=1, invert=0: writes 10..17 to addr
//    0..7, reads same; done rises 17 cycles after the start edge, pass=1,
//    err_count=0.
//  2 Same, invert=1: mem_wdata sequence 0xF5,0xF4,..,0xEE; pass=1.
//  3 Bench flips mem_rdata bit0 when addr 3 and 6 are read: err_count=2,
//    first_err_addr=3, pass=0.
//  4 Pulse start during WRITE and READ: ignored; single run, done timing as 1.
//  5 Assert rst during WRITE at addr 4: mem_wen=0 and busy=0 without a clock
//    edge; after release, state IDLE, done=0; new start runs to pass=1.
//  6 RD_LAT=0 with combinational-read memory, DEPTH=32: done 64 cycles after
//    start; an all-ones stuck mem_rdata gives err_count=32, first_err_addr=0
//    (expected 0xFF at addr 0xF5 = 245-10, outside depth, so all mismatch).

Source files
------------

// File: rtl/reg_mem_bist.sv
// Power-on self-test initiator for a reg_mem style register memory port.
// Writes (a + SEED) or its inverse to every word, reads back, counts mismatches.
module reg_mem_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int SEED       = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  invert,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wen_q, wen_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ADDR_WIDTH:0]     err_q, err_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic                    invert_q, invert_d;

    logic                    cmp_valid;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic [DATA_WIDTH-1:0]   cmp_exp;

    // Truncation to DATA_WIDTH happens before the optional inversion.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic inv);
        logic [DATA_WIDTH-1:0] w;
        w = DATA_WIDTH'(a) + DATA_WIDTH'(SEED);
        return inv ? ~w : w;
    endfunction

    // Expected word and address ride beside the read request for RD_LAT cycles.
    if (RD_LAT == 0) begin : g_cmp_comb
        assign cmp_valid = (state_q == S_READ);
        assign cmp_addr  = addr_q;
        assign cmp_exp   = wdata_q;
    end else begin : g_cmp_pipe
        logic                  pipe_valid_q, pipe_valid_d;
        logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
        logic [DATA_WIDTH-1:0] pipe_exp_q, pipe_exp_d;

        always_comb begin
            pipe_valid_d = (state_q == S_READ);
            pipe_addr_d  = addr_q;
            pipe_exp_d   = wdata_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_valid_q <= 1'b0;
                pipe_addr_q  <= '0;
                pipe_exp_q   <= '0;
            end else begin
                pipe_valid_q <= pipe_valid_d;
                pipe_addr_q  <= pipe_addr_d;
                pipe_exp_q   <= pipe_exp_d;
            end
        end

        assign cmp_valid = pipe_valid_q;
        assign cmp_addr  = pipe_addr_q;
        assign cmp_exp   = pipe_exp_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = wen_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        first_d  = first_q;
        invert_d = invert_q;

        if (cmp_valid && (mem_rdata != cmp_exp)) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) begin
                first_d = cmp_addr;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WRITE;
                    invert_d = invert;
                    addr_d   = '0;
                    wdata_d  = pattern('0, invert);
                    wen_d    = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    first_d  = '0;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    wdata_d = pattern('0, invert_q);
                    wen_d   = 1'b0;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    wdata_d = pattern(addr_q + ADDR_ONE, invert_q);
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    wdata_d = '0;
                    if (RD_LAT == 0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    wdata_d = pattern(addr_q + ADDR_ONE, invert_q);
                end
            end
            S_DRAIN: begin
                // Last compare lands on this edge; pass must include it.
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            invert_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
            invert_q <= invert_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wen        = wen_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_reg_mem_bist.sv
// Bench for reg_mem_bist: a synchronous-read memory (RD_LAT=1, DEPTH=8) and a
// combinational-read memory (RD_LAT=0, DEPTH=32), each with injectable read faults.
module tb_reg_mem_bist;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int SEED = 10;
    localparam int DA   = 8;
    localparam int DB   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          start_a = 1'b0, invert_a = 1'b0;
    logic [AW-1:0] addr_a, ferr_a;
    logic [DW-1:0] wdata_a, rdata_a;
    logic          wen_a, busy_a, done_a, pass_a;
    logic [AW:0]   errc_a;

    logic          start_b = 1'b0, invert_b = 1'b0;
    logic [AW-1:0] addr_b, ferr_b;
    logic [DW-1:0] wdata_b, rdata_b;
    logic          wen_b, busy_b, done_b, pass_b;
    logic [AW:0]   errc_b;

    reg_mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DA), .SEED(SEED), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .invert(invert_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wen(wen_a), .mem_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(errc_a), .first_err_addr(ferr_a)
    );

    reg_mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DB), .SEED(SEED), .RD_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .invert(invert_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wen(wen_b), .mem_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(errc_b), .first_err_addr(ferr_b)
    );

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] cor_a [32];
    logic [DW-1:0] mem_b [32];
    logic [DW-1:0] cor_b [32];
    logic          stuck_b = 1'b0;

    always @(posedge clk) begin
        if (wen_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a] ^ cor_a[addr_a];
    end

    always @(posedge clk) begin
        if (wen_b) mem_b[addr_b] <= wdata_b;
    end
    assign rdata_b = stuck_b ? 8'hFF : (mem_b[addr_b] ^ cor_b[addr_b]);

    function automatic logic [7:0] pat(input int a, input logic inv);
        int v;
        v = (a + SEED) % 256;
        if (inv) v = 255 - v;
        return 8'(v);
    endfunction

    // Write-side monitors: every write of a run must hit addresses 0,1,2.. with pat().
    int wr_idx_a = 0, wr_tot_a = 0, wr_bad_a = 0;
    int wr_idx_b = 0, wr_tot_b = 0, wr_bad_b = 0;
    always @(negedge clk) begin
        if (wen_a) begin
            if (int'(addr_a) != wr_idx_a || wdata_a !== pat(wr_idx_a, invert_a))
                wr_bad_a <= wr_bad_a + 1;
            wr_idx_a <= wr_idx_a + 1;
            wr_tot_a <= wr_tot_a + 1;
        end else begin
            wr_idx_a <= 0;
        end
    end
    always @(negedge clk) begin
        if (wen_b) begin
            if (int'(addr_b) != wr_idx_b || wdata_b !== pat(wr_idx_b, invert_b))
                wr_bad_b <= wr_bad_b + 1;
            wr_idx_b <= wr_idx_b + 1;
            wr_tot_b <= wr_tot_b + 1;
        end else begin
            wr_idx_b <= 0;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: readback of word a is stuck value or written pattern xor injected fault.
    function automatic void model_run(input bit b, input logic inv, input logic stuck,
                                      output int errs, output int first);
        int depth;
        logic [7:0] obs;
        depth = b ? DB : DA;
        errs  = 0;
        first = 0;
        for (int a = 0; a < depth; a++) begin
            obs = stuck ? 8'hFF : (pat(a, inv) ^ (b ? cor_b[a] : cor_a[a]));
            if (obs != pat(a, inv)) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
    endfunction

    task automatic run(input bit b, input logic inv, input logic stuck, input bit pulse,
                       input string tag);
        int n, exp_err, exp_first, depth, tot0, bad0;
        depth = b ? DB : DA;
        if (b) stuck_b = stuck;
        model_run(b, inv, stuck, exp_err, exp_first);
        @(negedge clk);
        tot0 = b ? wr_tot_b : wr_tot_a;
        bad0 = b ? wr_bad_b : wr_bad_a;
        if (b) begin start_b = 1'b1; invert_b = inv; end
        else   begin start_a = 1'b1; invert_a = inv; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, " busy_at_start"}, int'(b ? busy_b : busy_a), 1);
        check({tag, " done_cleared"},  int'(b ? done_b : done_a), 0);
        check({tag, " first_wen"},     int'(b ? wen_b : wen_a), 1);
        n = 0;
        while (!(b ? done_b : done_a) && n < 300) begin
            if (!b) start_a = pulse && (n == 3 || n == 12);
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b0;
        check({tag, " done_latency"}, n, b ? 2 * DB : 2 * DA + 1);
        check({tag, " busy_end"},  int'(b ? busy_b : busy_a), 0);
        check({tag, " pass"},      int'(b ? pass_b : pass_a), (exp_err == 0) ? 1 : 0);
        check({tag, " err_count"}, int'(b ? errc_b : errc_a), exp_err);
        check({tag, " first_err"}, int'(b ? ferr_b : ferr_a), exp_first);
        check({tag, " done_wen"},  int'(b ? wen_b : wen_a), 0);
        check({tag, " done_addr"}, int'(b ? addr_b : addr_a), 0);
        @(negedge clk);
        check({tag, " writes"},    (b ? wr_tot_b : wr_tot_a) - tot0, depth);
        check({tag, " write_data"}, (b ? wr_bad_b : wr_bad_a) - bad0, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done_held"}, int'(b ? done_b : done_a), 1);
        check({tag, " err_held"},  int'(b ? errc_b : errc_a), exp_err);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0; cor_a[i] = '0; mem_b[i] = '0; cor_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset wen_a",  int'(wen_a), 0);
        check("reset addr_a", int'(addr_a), 0);
        check("reset wdata_a", int'(wdata_a), 0);
        check("reset busy_a", int'(busy_a), 0);
        check("reset done_a", int'(done_a), 0);
        check("reset pass_a", int'(pass_a), 0);
        check("reset errc_a", int'(errc_a), 0);
        check("reset ferr_a", int'(ferr_a), 0);
        check("reset busy_b", int'(busy_b), 0);
        check("reset done_b", int'(done_b), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run(1'b0, 1'b0, 1'b0, 1'b0, "t1_plain");
        run(1'b0, 1'b1, 1'b0, 1'b0, "t2_invert");

        cor_a[3] = 8'h01;
        cor_a[6] = 8'h01;
        run(1'b0, 1'b0, 1'b0, 1'b0, "t3_flip");
        check("t3 err_const",   int'(errc_a), 2);
        check("t3 first_const", int'(ferr_a), 3);
        cor_a[3] = 8'h00;
        cor_a[6] = 8'h00;

        run(1'b0, 1'b0, 1'b0, 1'b1, "t4_pulse");

        // Asynchronous abort in the middle of the write pass.
        @(negedge clk);
        start_a = 1'b1; invert_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (!(wen_a && addr_a == 5'd4) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5 reached_addr4", int'(addr_a), 4);
        #2 rst = 1'b1;
        #1;
        check("t5 async_wen",  int'(wen_a), 0);
        check("t5 async_busy", int'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5 post_done", int'(done_a), 0);
        check("t5 post_busy", int'(busy_a), 0);
        check("t5 post_wen",  int'(wen_a), 0);
        run(1'b0, 1'b0, 1'b0, 1'b0, "t5_rerun");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++)
                cor_a[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), "rand_a");
        end

        run(1'b1, 1'b0, 1'b1, 1'b0, "t6_stuck");
        check("t6 err_const",   int'(errc_b), 32);
        check("t6 first_const", int'(ferr_b), 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, "t6_clean");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++)
                cor_b[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand_b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
